alu_issue: RTL and testbench

//  Issue stage directly upstream of the ALU. Accepts one decoded instruction at a time from the decoder
//  (valid/ready), reads rs1/rs2 from the register file, bypasses the ALU write-back value, and issues a

---
 rtl/alu_issue_pkg.sv | 47 ++++
 rtl/alu_issue_opnd_bypass.sv | 22 ++
 rtl/alu_issue.sv | 125 ++++++++++++
 tb/tb_alu_issue.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: decoded control, FSM encoding, hold-register payload.
package alu_issue_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned REG_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_REM  = 4'd12
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
        logic    use_imm;
        logic    is_word;
        logic    is_br;
    } InstAct;

    // Bit 0 = hold register valid, bit 1 = ALU op in flight.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        HOLD      = 2'b01,
        BUSY      = 2'b10,
        BUSY_HOLD = 2'b11
    } issue_state_e;

    typedef struct packed {
        InstAct              act;
        logic [REG_W-1:0]    rs1;
        logic [REG_W-1:0]    rs2;
        logic [REG_W-1:0]    rd;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     pc;
    } hold_t;

endpackage

// File: rtl/alu_issue_opnd_bypass.sv
// Source operand select: x0 reads zero, a same-cycle ALU write-back wins over the register file.
module opnd_bypass
    import alu_issue_pkg::*;
(
    input  logic [REG_W-1:0] i_rs,
    input  logic [XLEN-1:0]  i_rf_rdata,
    input  logic             i_wb_vld,
    input  logic [REG_W-1:0] i_wb_addr,
    input  logic [XLEN-1:0]  i_wb_data,
    output logic [XLEN-1:0]  o_opnd_c
);

    always_comb begin
        o_opnd_c = i_rf_rdata;
        if (i_rs == '0) begin
            o_opnd_c = '0;
        end else if (i_wb_vld && (i_wb_addr == i_rs)) begin
            o_opnd_c = i_wb_data;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Issue stage in front of a single-op ALU: one held instruction, one op in flight,
// write-back bypass on operands, registered one-cycle request pulse.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             id_vld,
    output logic             id_rdy,
    input  InstAct           id_inst_act,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_pc,
    output logic [REG_W-1:0] rf_raddr1,
    output logic [REG_W-1:0] rf_raddr2,
    input  logic [XLEN-1:0]  rf_rdata1,
    input  logic [XLEN-1:0]  rf_rdata2,
    output logic             iss_vld,
    output InstAct           iss_inst_act,
    output logic [REG_W-1:0] iss_dst_id,
    output logic [XLEN-1:0]  iss_src1,
    output logic [XLEN-1:0]  iss_src2,
    output logic [XLEN-1:0]  iss_imm,
    output logic [XLEN-1:0]  iss_pc,
    input  logic             alu_wb_vld,
    input  logic [REG_W-1:0] alu_wb_addr,
    input  logic [XLEN-1:0]  alu_wb_data,
    output logic             iss_err,
    output logic [CNT_W-1:0] perf_issue_cnt,
    output logic [CNT_W-1:0] perf_stall_cnt
);

    issue_state_e    r_state;
    hold_t           r_hold;

    logic            w_hv;
    logic            w_busy;
    logic            w_fire;
    logic            w_accept;
    logic            w_hv_nxt;
    logic            w_busy_nxt;
    logic [XLEN-1:0] w_opnd1;
    logic [XLEN-1:0] w_opnd2;

    assign w_hv   = (r_state == HOLD) || (r_state == BUSY_HOLD);
    assign w_busy = (r_state == BUSY) || (r_state == BUSY_HOLD);

    // A write-back frees the ALU in the same cycle, so the held op can go immediately.
    assign w_fire     = w_hv & (~w_busy | alu_wb_vld) & ~flush;
    assign id_rdy     = rst_n & ~flush & (~w_hv | w_fire);
    assign w_accept   = id_vld & id_rdy;
    assign w_hv_nxt   = ~flush & (w_accept | (w_hv & ~w_fire));
    assign w_busy_nxt = w_fire | (w_busy & ~alu_wb_vld);

    assign rf_raddr1 = r_hold.rs1;
    assign rf_raddr2 = r_hold.rs2;

    opnd_bypass u_byp1 (
        .i_rs       (r_hold.rs1),
        .i_rf_rdata (rf_rdata1),
        .i_wb_vld   (alu_wb_vld),
        .i_wb_addr  (alu_wb_addr),
        .i_wb_data  (alu_wb_data),
        .o_opnd_c   (w_opnd1)
    );

    opnd_bypass u_byp2 (
        .i_rs       (r_hold.rs2),
        .i_rf_rdata (rf_rdata2),
        .i_wb_vld   (alu_wb_vld),
        .i_wb_addr  (alu_wb_addr),
        .i_wb_data  (alu_wb_data),
        .o_opnd_c   (w_opnd2)
    );

    // State, hold register, issue outputs and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_hold         <= '0;
            iss_vld        <= 1'b0;
            iss_inst_act   <= '0;
            iss_dst_id     <= '0;
            iss_src1       <= '0;
            iss_src2       <= '0;
            iss_imm        <= '0;
            iss_pc         <= '0;
            iss_err        <= 1'b0;
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            r_state <= issue_state_e'({w_busy_nxt, w_hv_nxt});
            iss_vld <= w_fire;

            if (w_accept) begin
                r_hold <= '{act: id_inst_act, rs1: id_rs1, rs2: id_rs2,
                            rd: id_rd, imm: id_imm, pc: id_pc};
            end

            if (w_fire) begin
                iss_inst_act   <= r_hold.act;
                iss_dst_id     <= r_hold.rd;
                iss_src1       <= w_opnd1;
                iss_src2       <= w_opnd2;
                iss_imm        <= r_hold.imm;
                iss_pc         <= r_hold.pc;
                perf_issue_cnt <= perf_issue_cnt + CNT_W'(1);
            end

            if (alu_wb_vld && !w_busy) begin
                iss_err <= 1'b1;
            end

            if (w_hv && w_busy && !alu_wb_vld) begin
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Scenario bench for alu_issue: expected issues are queued at stimulus time and popped at the pulse.
module tb_alu_issue;
    import alu_issue_pkg::*;

    localparam int unsigned CW = 8;

    typedef struct packed {
        logic             vld;
        InstAct           act;
        logic [REG_W-1:0] dst;
        logic [XLEN-1:0]  s1;
        logic [XLEN-1:0]  s2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
    } iss_t;

    localparam InstAct ACT_ADDI = '{op: ALU_ADD, use_imm: 1'b1, is_word: 1'b0, is_br: 1'b0};
    localparam InstAct ACT_ADD  = '{op: ALU_ADD, use_imm: 1'b0, is_word: 1'b0, is_br: 1'b0};
    localparam InstAct ACT_XOR  = '{op: ALU_XOR, use_imm: 1'b0, is_word: 1'b1, is_br: 1'b0};
    localparam InstAct ACT_DIV  = '{op: ALU_DIV, use_imm: 1'b0, is_word: 1'b0, is_br: 1'b0};

    logic             clk = 1'b0;
    logic             rst_n, flush, id_vld, id_rdy;
    InstAct           id_inst_act, iss_inst_act;
    logic [REG_W-1:0] id_rs1, id_rs2, id_rd, rf_raddr1, rf_raddr2, iss_dst_id, alu_wb_addr;
    logic [XLEN-1:0]  id_imm, id_pc, rf_rdata1, rf_rdata2;
    logic [XLEN-1:0]  iss_src1, iss_src2, iss_imm, iss_pc, alu_wb_data;
    logic             iss_vld, alu_wb_vld, iss_err;
    logic [CW-1:0]    perf_issue_cnt, perf_stall_cnt;

    logic [XLEN-1:0]  rf [32];
    iss_t             q[$];
    iss_t             e;
    int               n_cmp = 0;
    int               n_bad = 0;
    int               n_pushed = 0;
    logic [CW-1:0]    exp_issue = '0;
    logic [CW-1:0]    exp_stall = '0;
    int               m_pulses = 0;
    logic             m_prev = 1'b0;
    logic             m_consec = 1'b0;

    always #5 clk = ~clk;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    alu_issue #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_vld(id_vld), .id_rdy(id_rdy), .id_inst_act(id_inst_act),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm), .id_pc(id_pc),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .iss_vld(iss_vld), .iss_inst_act(iss_inst_act), .iss_dst_id(iss_dst_id),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_imm(iss_imm), .iss_pc(iss_pc),
        .alu_wb_vld(alu_wb_vld), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
        .iss_err(iss_err), .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    // Pulse monitor: counts every request pulse and notes back-to-back highs.
    always @(negedge clk) begin
        if (iss_vld) begin
            m_pulses <= m_pulses + 1;
            if (m_prev) m_consec <= 1'b1;
        end
        m_prev <= iss_vld;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, bench still running");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic iss_t obs();
        return '{iss_vld, iss_inst_act, iss_dst_id, iss_src1, iss_src2, iss_imm, iss_pc};
    endfunction

    task automatic drive_id(input InstAct a, input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                            input logic [REG_W-1:0] rd, input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc);
        id_inst_act = a; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_imm = imm; id_pc = pc;
        id_vld = 1'b1;
    endtask

    task automatic push_exp(input InstAct a, input logic [REG_W-1:0] rd, input logic [XLEN-1:0] s1,
                            input logic [XLEN-1:0] s2, input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc);
        q.push_back('{1'b1, a, rd, s1, s2, imm, pc});
        n_pushed++;
        exp_issue++;
    endtask

    task automatic set_wb(input logic v, input logic [REG_W-1:0] a, input logic [XLEN-1:0] d);
        alu_wb_vld = v; alu_wb_addr = a; alu_wb_data = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_id(ACT_ADD, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2);
        #1;
        n_cmp++;
        if (id_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_id_rdy: got %b want 0", id_rdy); end
        tick(); tick();
        n_cmp++;
        if ({iss_vld, iss_err} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: vld/err got %b%b want 00", iss_vld, iss_err); end
        n_cmp++;
        if ({perf_issue_cnt, perf_stall_cnt} !== '0) begin
            n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", perf_issue_cnt, perf_stall_cnt);
        end
        n_cmp++;
        if (obs() !== '0) begin n_bad++; $display("FAIL reset_iss_data: got %p want all zero", obs()); end
        id_vld = 1'b0;
        rst_n  = 1'b1;
        tick();
    endtask

    task automatic test_single_op();
        rf[1] = 64'd10;
        drive_id(ACT_ADDI, 5'd1, 5'd0, 5'd5, 64'd7, 64'h100);
        push_exp(ACT_ADDI, 5'd5, 64'd10, 64'd0, 64'd7, 64'h100);
        #1;
        n_cmp++;
        if (id_rdy !== 1'b1) begin n_bad++; $display("FAIL single_rdy: got %b want 1", id_rdy); end
        tick();
        id_vld = 1'b0;
        n_cmp++;
        if (iss_vld !== 1'b0 || rf_raddr1 !== 5'd1) begin
            n_bad++; $display("FAIL single_lat1: vld=%b raddr1=%0d want 0/1", iss_vld, rf_raddr1);
        end
        tick();
        e = q.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL single_issue: got %p want %p", obs(), e); end
        tick();
        n_cmp++;
        if (iss_vld !== 1'b0 || iss_src1 !== 64'd10 || iss_dst_id !== 5'd5) begin
            n_bad++; $display("FAIL single_pulse_hold: vld=%b src1=%0d dst=%0d want 0/10/5", iss_vld, iss_src1, iss_dst_id);
        end
        set_wb(1'b1, 5'd5, 64'h11);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
        n_cmp++;
        if (iss_err !== 1'b0 || perf_issue_cnt !== exp_issue) begin
            n_bad++; $display("FAIL single_cnt: err=%b issue_cnt=%0d want 0/%0d", iss_err, perf_issue_cnt, exp_issue);
        end
    endtask

    task automatic test_back_to_back();
        rf[2] = 64'h20; rf[3] = 64'h0; rf[4] = 64'h44;
        drive_id(ACT_ADD, 5'd2, 5'd4, 5'd3, 64'h0, 64'h200);
        push_exp(ACT_ADD, 5'd3, 64'h20, 64'h44, 64'h0, 64'h200);
        tick();
        drive_id(ACT_XOR, 5'd3, 5'd4, 5'd4, 64'h9, 64'h204);
        push_exp(ACT_XOR, 5'd4, 64'h55, 64'h44, 64'h9, 64'h204);
        #1;
        n_cmp++;
        if (id_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy_on_fire: got %b want 1", id_rdy); end
        tick();
        id_vld = 1'b0;
        e = q.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL b2b_issue_a: got %p want %p", obs(), e); end
        exp_stall++;
        tick();
        n_cmp++;
        if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL b2b_wait: iss_vld got %b want 0", iss_vld); end
        set_wb(1'b1, 5'd3, 64'h55);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
        e = q.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL b2b_issue_b: got %p want %p", obs(), e); end
        n_cmp++;
        if (perf_stall_cnt !== exp_stall) begin
            n_bad++; $display("FAIL b2b_stall: got %0d want %0d", perf_stall_cnt, exp_stall);
        end
        set_wb(1'b1, 5'd4, 64'h1);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
    endtask

    task automatic test_x0();
        rf[0] = 64'hdead; rf[6] = 64'h66;
        drive_id(ACT_ADD, 5'd6, 5'd0, 5'd10, 64'h0, 64'h300);
        push_exp(ACT_ADD, 5'd10, 64'h66, 64'h0, 64'h0, 64'h300);
        tick();
        drive_id(ACT_ADDI, 5'd6, 5'd0, 5'd7, 64'h3, 64'h304);
        push_exp(ACT_ADDI, 5'd7, 64'h66, 64'h0, 64'h3, 64'h304);
        tick();
        id_vld = 1'b0;
        e = q.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL x0_rf_dead: got %p want %p", obs(), e); end
        exp_stall++;
        tick();
        set_wb(1'b1, 5'd0, 64'hbeef);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
        e = q.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL x0_wb_addr0: got %p want %p", obs(), e); end
        set_wb(1'b1, 5'd7, 64'h2);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
    endtask

    task automatic test_busy_hold();
        logic rdy_seen;
        rf[8] = 64'h0;
        drive_id(ACT_DIV, 5'd1, 5'd6, 5'd8, 64'h0, 64'h400);
        push_exp(ACT_DIV, 5'd8, 64'd10, 64'h66, 64'h0, 64'h400);
        tick();
        drive_id(ACT_ADD, 5'd8, 5'd0, 5'd9, 64'h0, 64'h404);
        push_exp(ACT_ADD, 5'd9, 64'h88, 64'h0, 64'h0, 64'h404);
        tick();
        e = q.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL hold_issue_div: got %p want %p", obs(), e); end
        drive_id(ACT_XOR, 5'd1, 5'd1, 5'd11, 64'h0, 64'h408);
        rdy_seen = 1'b0;
        for (int i = 0; i < 34; i++) begin
            rdy_seen = rdy_seen | id_rdy;
            tick();
        end
        exp_stall = exp_stall + CW'(34);
        id_vld = 1'b0;
        n_cmp++;
        if (rdy_seen !== 1'b0) begin n_bad++; $display("FAIL hold_rdy_low: id_rdy seen %b want 0", rdy_seen); end
        n_cmp++;
        if (perf_stall_cnt !== exp_stall) begin
            n_bad++; $display("FAIL hold_stall34: got %0d want %0d", perf_stall_cnt, exp_stall);
        end
        set_wb(1'b1, 5'd8, 64'h88);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
        e = q.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL hold_issue_on_wb: got %p want %p", obs(), e); end
        n_cmp++;
        if (perf_issue_cnt !== exp_issue) begin
            n_bad++; $display("FAIL hold_issue_cnt: got %0d want %0d", perf_issue_cnt, exp_issue);
        end
        set_wb(1'b1, 5'd9, 64'h3);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
    endtask

    task automatic test_flush();
        logic vld_seen;
        drive_id(ACT_ADD, 5'd1, 5'd0, 5'd12, 64'h0, 64'h500);
        push_exp(ACT_ADD, 5'd12, 64'd10, 64'h0, 64'h0, 64'h500);
        tick();
        drive_id(ACT_ADD, 5'd1, 5'd1, 5'd13, 64'h0, 64'h504);
        tick();
        e = q.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL flush_issue_p: got %p want %p", obs(), e); end
        drive_id(ACT_ADD, 5'd1, 5'd1, 5'd14, 64'h0, 64'h508);
        flush = 1'b1;
        set_wb(1'b1, 5'd12, 64'h5);
        #1;
        n_cmp++;
        if (id_rdy !== 1'b0) begin n_bad++; $display("FAIL flush_rdy: got %b want 0", id_rdy); end
        tick();
        flush = 1'b0; id_vld = 1'b0;
        set_wb(1'b0, 5'd0, 64'h0);
        vld_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld_seen = vld_seen | iss_vld;
            tick();
        end
        n_cmp++;
        if (vld_seen !== 1'b0 || iss_err !== 1'b0) begin
            n_bad++; $display("FAIL flush_no_issue: vld_seen=%b err=%b want 0/0", vld_seen, iss_err);
        end
        drive_id(ACT_ADDI, 5'd1, 5'd0, 5'd15, 64'h1, 64'h50c);
        push_exp(ACT_ADDI, 5'd15, 64'd10, 64'h0, 64'h1, 64'h50c);
        tick();
        id_vld = 1'b0;
        tick();
        e = q.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL flush_busy_cleared: got %p want %p", obs(), e); end
        set_wb(1'b1, 5'd15, 64'h6);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
    endtask

    task automatic test_err_wrap();
        int n;
        set_wb(1'b1, 5'd1, 64'h7);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
        n_cmp++;
        if (iss_err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", iss_err); end
        tick(); tick(); tick();
        n_cmp++;
        if (iss_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", iss_err); end
        drive_id(ACT_ADD, 5'd1, 5'd0, 5'd16, 64'h0, 64'h600);
        push_exp(ACT_ADD, 5'd16, 64'd10, 64'h0, 64'h0, 64'h600);
        tick();
        drive_id(ACT_ADD, 5'd16, 5'd1, 5'd17, 64'h0, 64'h604);
        push_exp(ACT_ADD, 5'd17, 64'h77, 64'd10, 64'h0, 64'h604);
        tick();
        id_vld = 1'b0;
        e = q.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL wrap_issue: got %p want %p", obs(), e); end
        n = 255 - int'(exp_stall);
        for (int i = 0; i < n; i++) tick();
        exp_stall = 8'hff;
        n_cmp++;
        if (perf_stall_cnt !== exp_stall) begin n_bad++; $display("FAIL wrap_max: got %0d want %0d", perf_stall_cnt, exp_stall); end
        tick();
        exp_stall = 8'h00;
        n_cmp++;
        if (perf_stall_cnt !== exp_stall) begin n_bad++; $display("FAIL wrap_zero: got %0d want %0d", perf_stall_cnt, exp_stall); end
        set_wb(1'b1, 5'd16, 64'h77);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
        e = q.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL wrap_issue_after: got %p want %p", obs(), e); end
        set_wb(1'b1, 5'd17, 64'h8);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_issue = '0; exp_stall = '0;
        n_cmp++;
        if (iss_err !== 1'b0 || perf_issue_cnt !== exp_issue || perf_stall_cnt !== exp_stall) begin
            n_bad++; $display("FAIL err_reset_clear: err=%b cnt=%0d/%0d want 0/0/0", iss_err, perf_issue_cnt, perf_stall_cnt);
        end
    endtask

    task automatic test_reset_midop();
        drive_id(ACT_ADDI, 5'd1, 5'd0, 5'd18, 64'h2, 64'h700);
        push_exp(ACT_ADDI, 5'd18, 64'd10, 64'h0, 64'h2, 64'h700);
        tick();
        id_vld = 1'b0;
        tick();
        e = q.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL midop_issue: got %p want %p", obs(), e); end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_issue = '0; exp_stall = '0;
        set_wb(1'b1, 5'd18, 64'h9);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
        n_cmp++;
        if (iss_err !== 1'b1 || perf_issue_cnt !== exp_issue) begin
            n_bad++; $display("FAIL midop_err: err=%b issue_cnt=%0d want 1/%0d", iss_err, perf_issue_cnt, exp_issue);
        end
    endtask

    task automatic test_final();
        tick(); tick();
        n_cmp++;
        if (m_pulses !== n_pushed || q.size() !== 0) begin
            n_bad++; $display("FAIL pulse_count: pulses=%0d queued_left=%0d want %0d/0", m_pulses, q.size(), n_pushed);
        end
        n_cmp++;
        if (m_consec !== 1'b0) begin n_bad++; $display("FAIL no_consec: back-to-back iss_vld seen %b want 0", m_consec); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 64'h0;
        rst_n = 1'b0; flush = 1'b0; id_vld = 1'b0;
        id_inst_act = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_imm = '0; id_pc = '0;
        set_wb(1'b0, 5'd0, 64'h0);
        tick();
        test_reset();
        test_single_op();
        test_back_to_back();
        test_x0();
        test_busy_hold();
        test_flush();
        test_err_wrap();
        test_reset_midop();
        test_final();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
